// File: rtl/window_3x3.sv
// 3x3 sliding-window generator over a padded raster stream (two line buffers + 3x3 register window).
// Latency: window for an accepted pixel appears exactly 1 cycle after that pixel is accepted.
// No backpressure: din is accepted whenever din_vld=1; idle cycles freeze all state. Option: WINDOW_STRIDE2_EN.
module window_3x3 #(
    parameter int N       = 8,
    parameter int CHANNEL = 3,
    parameter int SIZE    = 32,
    parameter int PADDING = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_vld,
    input  logic [CHANNEL*N-1:0]     din,
    output logic [9*CHANNEL*N-1:0]   win_dout,
    output logic                     win_vld,
    output logic                     win_end
);
    localparam int P  = CHANNEL * N;
    localparam int W  = SIZE + 2 * PADDING;
    localparam int CW = $clog2(W + 1);
    localparam int AW = $clog2(W);
    localparam logic [CW-1:0] W_M1 = CW'(W - 1);
    localparam logic [CW-1:0] TWO  = CW'(2);
    localparam logic [CW-1:0] ONE  = CW'(1);
`ifdef WINDOW_STRIDE2_EN
    // Last even coordinate in the padded frame; the final stride-2 window sits there.
    localparam logic [CW-1:0] LAST_EVEN = CW'(((W - 1) / 2) * 2);
`endif

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t          state_q;
    logic [CW-1:0]   col_q, row_q;
    logic [CW-1:0]   cur_col, cur_row;
    logic [AW-1:0]   lb_idx;
    logic [P-1:0]    lb0_q [W];    // previous row (r-1), indexed by column
    logic [P-1:0]    lb1_q [W];    // row before that (r-2), indexed by column
    logic [P-1:0]    win_q [9];
    logic [P-1:0]    win_d [9];
    logic [9*P-1:0]  win_flat;
    logic [9*P-1:0]  win_dout_q;
    logic            win_vld_q, win_end_q;
    logic            last_px, in_run, emit, is_end;

    // Position of the pixel on din; IDLE means this is the first pixel of a frame.
    always_comb begin
        cur_col = (state_q == IDLE) ? '0 : col_q;
        cur_row = (state_q == IDLE) ? '0 : row_q;
        lb_idx  = cur_col[AW-1:0];
        last_px = (cur_col == W_M1) && (cur_row == W_M1);
        in_run  = (cur_row >= TWO) && (cur_col >= TWO);
`ifdef WINDOW_STRIDE2_EN
        emit    = in_run && !cur_row[0] && !cur_col[0];
        is_end  = (cur_row == LAST_EVEN) && (cur_col == LAST_EVEN);
`else
        emit    = in_run;
        is_end  = last_px;
`endif
    end

    // Next window: every row shifts left by one, new right column = (r-2,c), (r-1,c), (r,c).
    always_comb begin
        for (int k = 0; k < 9; k++) win_d[k] = win_q[k];
        for (int r = 0; r < 3; r++) begin
            win_d[r*3+0] = win_q[r*3+1];
            win_d[r*3+1] = win_q[r*3+2];
        end
        win_d[2] = lb1_q[lb_idx];
        win_d[5] = lb0_q[lb_idx];
        win_d[8] = din;
    end

    // Flatten the next window into the output tap layout (tap k at bits k*P).
    always_comb begin
        win_flat = '0;
        for (int k = 0; k < 9; k++) win_flat[k*P +: P] = win_d[k];
    end

    // Data path storage: line buffers and window shift only on accepted pixels; no reset needed
    // because a valid window only ever contains pixels written earlier in the same frame.
    always_ff @(posedge clk) begin
        if (!rst && din_vld) begin
            lb0_q[lb_idx] <= din;
            lb1_q[lb_idx] <= lb0_q[lb_idx];
            win_q         <= win_d;
        end
    end

    // Position counters, frame FSM and registered window outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            win_vld_q  <= 1'b0;
            win_end_q  <= 1'b0;
            win_dout_q <= '0;
        end else begin
            win_vld_q <= 1'b0;
            win_end_q <= 1'b0;
            if (din_vld) begin
                if (cur_col == W_M1) begin
                    col_q <= '0;
                    row_q <= (cur_row == W_M1) ? '0 : cur_row + ONE;
                end else begin
                    col_q <= cur_col + ONE;
                    row_q <= cur_row;
                end
                if (last_px)     state_q <= IDLE;
                else if (in_run) state_q <= RUN;
                else             state_q <= FILL;
                if (emit) begin
                    win_vld_q  <= 1'b1;
                    win_end_q  <= is_end;
                    win_dout_q <= win_flat;
                end
            end
        end
    end

    assign win_dout = win_dout_q;
    assign win_vld  = win_vld_q;
    assign win_end  = win_end_q;
endmodule

// File: tb/tb_window_3x3.sv
module tb_window_3x3;
    localparam int W    = 6;
    localparam int NPIX = W * W;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_vld;
    logic [7:0]  din;
    logic [71:0] win_dout;
    logic        win_vld;
    logic        win_end;

    always #5 clk = ~clk;

    window_3x3 #(.N(8), .CHANNEL(1), .SIZE(4), .PADDING(1)) dut (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din),
        .win_dout(win_dout), .win_vld(win_vld), .win_end(win_end)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the current frame image, indexed by padded (row, col).
    logic [7:0]  img [W][W];
    int          idx;
    logic        exp_vld, exp_end;
    logic [71:0] exp_dout;

    function automatic bit model_emits(int r, int c);
`ifdef WINDOW_STRIDE2_EN
        return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
        return (r >= 2) && (c >= 2);
`endif
    endfunction

    function automatic bit model_is_last(int r, int c);
`ifdef WINDOW_STRIDE2_EN
        return (r == ((W - 1) / 2) * 2) && (c == ((W - 1) / 2) * 2);
`else
        return (r == W - 1) && (c == W - 1);
`endif
    endfunction

    function automatic logic [71:0] model_win(int r, int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = img[r - 2 + k / 3][c - 2 + k % 3];
        return w;
    endfunction

    function automatic logic [71:0] mk9(int a0, int a1, int a2, int a3, int a4,
                                        int a5, int a6, int a7, int a8);
        return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0],
                a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    // Drive one cycle (pixel or idle) and advance the model; returns sampled 1 ns after the edge.
    task automatic drive(input logic [7:0] v, input logic vld);
        int r, c;
        din     = v;
        din_vld = vld;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        exp_vld = 1'b0;
        exp_end = 1'b0;
        if (vld) begin
            r = idx / W;
            c = idx % W;
            img[r][c] = v;
            if (model_emits(r, c)) begin
                exp_vld  = 1'b1;
                exp_end  = model_is_last(r, c);
                exp_dout = model_win(r, c);
            end
            idx = (idx + 1) % NPIX;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst     = 1'b1;
        din_vld = 1'b1;
        din     = 8'($urandom);
        repeat (cycles) @(posedge clk);
        #1;
        rst      = 1'b0;
        din_vld  = 1'b0;
        idx      = 0;
        exp_vld  = 1'b0;
        exp_end  = 1'b0;
        exp_dout = '0;
    endtask

    task automatic test_reset();
        do_reset(3);
        checks++;
        if (win_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld: got %b expected 0", win_vld);
        end
        checks++;
        if (win_end !== 1'b0) begin
            errors++; $display("FAIL reset_end: got %b expected 0", win_end);
        end
        checks++;
        if (win_dout !== 72'h0) begin
            errors++; $display("FAIL reset_dout: got %h expected 0", win_dout);
        end
    endtask

    // One full frame with no gaps; spec_vals selects pixel-index data instead of random data.
    task automatic test_continuous(input bit spec_vals);
        int dut_wins = 0, model_wins = 0, ends = 0;
        logic [71:0] first_w = '0, last_w = '0;
        logic [7:0]  v;
        for (int i = 0; i < NPIX; i++) begin
            v = spec_vals ? 8'(i) : 8'($urandom);
            drive(v, 1'b1);
            checks++;
            if (win_vld !== exp_vld || win_end !== exp_end || win_dout !== exp_dout) begin
                errors++;
                $display("FAIL continuous px%0d: vld=%b end=%b dout=%h, expected vld=%b end=%b dout=%h",
                         i, win_vld, win_end, win_dout, exp_vld, exp_end, exp_dout);
            end
            if (exp_vld) model_wins++;
            if (win_vld === 1'b1) begin
                if (dut_wins == 0) first_w = win_dout;
                last_w = win_dout;
                dut_wins++;
            end
            if (win_end === 1'b1) ends++;
        end
        checks++;
        if (dut_wins != model_wins || ends != 1) begin
            errors++;
            $display("FAIL continuous_count: windows=%0d ends=%0d, expected windows=%0d ends=1",
                     dut_wins, ends, model_wins);
        end
`ifndef WINDOW_STRIDE2_EN
        if (spec_vals) begin
            checks++;
            if (dut_wins != 16 || first_w !== mk9(0, 1, 2, 6, 7, 8, 12, 13, 14)) begin
                errors++;
                $display("FAIL continuous_first: windows=%0d first=%h, expected 16 and %h",
                         dut_wins, first_w, mk9(0, 1, 2, 6, 7, 8, 12, 13, 14));
            end
            checks++;
            if (last_w !== mk9(21, 22, 23, 27, 28, 29, 33, 34, 35)) begin
                errors++;
                $display("FAIL continuous_last: got %h expected %h",
                         last_w, mk9(21, 22, 23, 27, 28, 29, 33, 34, 35));
            end
        end
`endif
    endtask

    // Idle cycles between pixels: fixed 3 or random 0..3; idle cycles must hold win_dout.
    task automatic test_gaps(input bit random_gap);
        int dut_wins = 0, model_wins = 0, ends = 0, g;
        for (int i = 0; i < NPIX; i++) begin
            drive(random_gap ? 8'($urandom) : 8'(i), 1'b1);
            checks++;
            if (win_vld !== exp_vld || win_end !== exp_end || win_dout !== exp_dout) begin
                errors++;
                $display("FAIL gaps px%0d: vld=%b end=%b dout=%h, expected vld=%b end=%b dout=%h",
                         i, win_vld, win_end, win_dout, exp_vld, exp_end, exp_dout);
            end
            if (exp_vld) model_wins++;
            if (win_vld === 1'b1) dut_wins++;
            if (win_end === 1'b1) ends++;
            g = random_gap ? $urandom_range(0, 3) : 3;
            for (int j = 0; j < g; j++) begin
                drive(8'($urandom), 1'b0);
                checks++;
                if (win_vld !== 1'b0 || win_end !== 1'b0 || win_dout !== exp_dout) begin
                    errors++;
                    $display("FAIL gaps_idle px%0d: vld=%b end=%b dout=%h, expected vld=0 end=0 dout=%h",
                             i, win_vld, win_end, win_dout, exp_dout);
                end
            end
        end
        checks++;
        if (dut_wins != model_wins || ends != 1) begin
            errors++;
            $display("FAIL gaps_count: windows=%0d ends=%0d, expected windows=%0d ends=1",
                     dut_wins, ends, model_wins);
        end
    endtask

    task automatic test_back_to_back();
        int dut_wins = 0, model_wins = 0, ends = 0;
        logic [71:0] w17 = '0;
        for (int i = 0; i < 2 * NPIX; i++) begin
            drive((i < NPIX) ? 8'(i) : 8'(i - NPIX + 100), 1'b1);
            checks++;
            if (win_vld !== exp_vld || win_end !== exp_end || win_dout !== exp_dout) begin
                errors++;
                $display("FAIL b2b px%0d: vld=%b end=%b dout=%h, expected vld=%b end=%b dout=%h",
                         i, win_vld, win_end, win_dout, exp_vld, exp_end, exp_dout);
            end
            if (exp_vld) model_wins++;
            if (win_vld === 1'b1) begin
                dut_wins++;
                if (dut_wins == 17) w17 = win_dout;
            end
            if (win_end === 1'b1) ends++;
        end
        checks++;
        if (dut_wins != model_wins || ends != 2) begin
            errors++;
            $display("FAIL b2b_count: windows=%0d ends=%0d, expected windows=%0d ends=2",
                     dut_wins, ends, model_wins);
        end
`ifndef WINDOW_STRIDE2_EN
        checks++;
        if (w17 !== mk9(100, 101, 102, 106, 107, 108, 112, 113, 114)) begin
            errors++;
            $display("FAIL b2b_window17: got %h expected %h",
                     w17, mk9(100, 101, 102, 106, 107, 108, 112, 113, 114));
        end
`endif
    endtask

    task automatic test_mid_reset();
        int dut_wins = 0, model_wins = 0;
        for (int i = 0; i < 20; i++) drive(8'($urandom), 1'b1);
        do_reset(1);
        checks++;
        if (win_vld !== 1'b0 || win_dout !== 72'h0) begin
            errors++;
            $display("FAIL midreset_clear: vld=%b dout=%h expected vld=0 dout=0", win_vld, win_dout);
        end
        for (int i = 0; i < NPIX; i++) begin
            drive(8'(i), 1'b1);
            checks++;
            if (win_vld !== exp_vld || win_end !== exp_end || win_dout !== exp_dout) begin
                errors++;
                $display("FAIL midreset px%0d: vld=%b end=%b dout=%h, expected vld=%b end=%b dout=%h",
                         i, win_vld, win_end, win_dout, exp_vld, exp_end, exp_dout);
            end
            if (exp_vld) model_wins++;
            if (win_vld === 1'b1) dut_wins++;
        end
        checks++;
        if (dut_wins != model_wins) begin
            errors++;
            $display("FAIL midreset_count: windows=%0d expected %0d", dut_wins, model_wins);
        end
    endtask

    initial begin
        rst      = 1'b1;
        din_vld  = 1'b0;
        din      = '0;
        idx      = 0;
        exp_vld  = 1'b0;
        exp_end  = 1'b0;
        exp_dout = '0;
        #1;
        test_reset();
        test_continuous(1'b1);
        test_continuous(1'b0);
        test_gaps(1'b0);
        test_gaps(1'b1);
        test_back_to_back();
        test_mid_reset();
        test_continuous(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
